// File: rtl/logic_op_pkg.sv
// Shared types for the stream logic unit.
//   op_e    : base bitwise operation carried in op[1:0]; op[OP_INV_BIT]
//             selects inversion of the final result.
//   state_e : packet-tracking state of the fold engine.
package logic_op_pkg;

    // OP_RSV is the unused base code. It evaluates as AND.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    // Bit of the 3-bit op code that inverts the final result.
    localparam int OP_INV_BIT = 2;

    typedef enum logic {
        IDLE  = 1'b0,   // no packet open
        ACCUM = 1'b1    // fold packet open, accumulator live
    } state_e;

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational WIDTH-bit bitwise operator: z = x op y.
// Inversion is not handled here. The caller applies it once, to the final result.
// Ports:
//   x, y : operands (WIDTH bits)
//   op   : base operation (op_e). OP_RSV behaves as OP_AND.
//   z    : result (WIDTH bits)
module logic_op_core
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  op_e              op,
    output logic [WIDTH-1:0] z
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign z[gi] = (op == OP_OR)  ? (x[gi] | y[gi]) :
                           (op == OP_XOR) ? (x[gi] ^ y[gi]) :
                                            (x[gi] & y[gi]);
        end
    endgenerate

endmodule

// File: rtl/stream_logic_unit.sv
// Registered bitwise logic unit with a valid/ready stream interface.
//   Pair mode (fold=0) : each beat produces inv(in_a op in_b).
//   Fold mode (fold=1) : a packet on in_a, terminated by in_last, produces
//                        inv(a0 op a1 op ... op an).
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   op[2:0], fold       : operation and mode. Sampled on the first beat of a fold packet.
//   in_valid/in_ready   : input handshake. in_ready = !out_valid || out_ready.
//   in_a, in_b, in_last : operands and packet delimiter
//   out_valid/out_ready : output handshake
//   out_data, out_beats : result and the saturating count of contributing beats
module stream_logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic             fold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_beats
);

    state_e             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2:0]         op_reg, op_next;
    logic               out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]   out_data_reg, out_data_next;
    logic [CNT_W-1:0]   out_beats_reg, out_beats_next;

    logic               accept;
    logic               fold_active;
    op_e                core_op;
    logic [WIDTH-1:0]   core_y;
    logic [WIDTH-1:0]   core_z;
    logic [WIDTH-1:0]   inv_mask;
    logic [CNT_W-1:0]   cnt_inc;

    // No skid buffer. A full output register blocks input unless it drains this cycle.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // An open packet means fold mode is in effect. The ACCUM state therefore
    // stands in for a latched fold flag, and only op needs to be held.
    assign fold_active = (state_reg == ACCUM);

    // One operator serves both paths. The second operand is in_b for pair
    // beats and the accumulator for continuing fold beats.
    assign core_op  = fold_active ? op_e'(op_reg[1:0]) : op_e'(op[1:0]);
    assign core_y   = fold_active ? acc_reg : in_b;
    assign inv_mask = {WIDTH{fold_active ? op_reg[OP_INV_BIT] : op[OP_INV_BIT]}};

    // Saturate instead of wrapping, so a long packet reports the maximum count.
    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x  (in_a),
        .y  (core_y),
        .op (core_op),
        .z  (core_z)
    );

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        op_next        = op_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_beats_next = out_beats_reg;

        // A transfer frees the register. A load below in the same cycle re-arms it.
        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (accept) begin
            case (state_reg)
                IDLE: begin
                    if (!fold) begin
                        out_data_next  = core_z ^ inv_mask;
                        out_beats_next = CNT_W'(1);
                        out_valid_next = 1'b1;
                    end else begin
                        op_next  = op;
                        acc_next = in_a;
                        cnt_next = CNT_W'(1);
                        if (in_last) begin
                            out_data_next  = in_a ^ inv_mask;
                            out_beats_next = CNT_W'(1);
                            out_valid_next = 1'b1;
                        end else begin
                            state_next = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    acc_next = core_z;
                    cnt_next = cnt_inc;
                    if (in_last) begin
                        out_data_next  = core_z ^ inv_mask;
                        out_beats_next = cnt_inc;
                        out_valid_next = 1'b1;
                        state_next     = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            op_reg        <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_beats_reg <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            op_reg        <= op_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_beats_reg <= out_beats_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_beats = out_beats_reg;

endmodule

// File: tb/tb_stream_logic_unit.sv
module tb_stream_logic_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] op = 3'b000;
    logic       fold = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid;
    logic [7:0] out_data, out_beats;
    logic       in_ready_s, out_valid_s;
    logic [7:0] out_data_s;
    logic [1:0] out_beats_s;

    always #5 clk = ~clk;

    stream_logic_unit #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .op(op), .fold(fold),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_beats(out_beats)
    );

    // Same stimulus, narrow counter. Used for the saturation checks.
    stream_logic_unit #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .op(op), .fold(fold),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_beats(out_beats_s)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] beats;
        logic [1:0] beats_s;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic logic [7:0] base_op(logic [7:0] x, logic [7:0] y, logic [1:0] o);
        case (o)
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return x & y;
        endcase
    endfunction

    task automatic push_exp(input logic [7:0] d, input int n);
        exp_t e;
        e.data    = d;
        e.beats   = (n > 255) ? 8'd255 : 8'(n);
        e.beats_s = (n > 3) ? 2'd3 : 2'(n);
        sb.push_back(e);
    endtask

    // Scoreboard: a result leaves the DUT when out_valid && out_ready at the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_result: got data=%02h beats=%0d, expected no result", out_data, out_beats);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total_cnt++;
                if (out_data !== e.data)
                    $display("FAIL result_data: got %02h, expected %02h", out_data, e.data);
                else pass_cnt++;
                total_cnt++;
                if (out_beats !== e.beats)
                    $display("FAIL result_beats: got %0d, expected %0d", out_beats, e.beats);
                else pass_cnt++;
                total_cnt++;
                if (out_valid_s !== 1'b1 || out_data_s !== e.data || out_beats_s !== e.beats_s)
                    $display("FAIL sat_result: got v=%0b data=%02h beats=%0d, expected v=1 data=%02h beats=%0d",
                             out_valid_s, out_data_s, out_beats_s, e.data, e.beats_s);
                else pass_cnt++;
                $display("result data=%02h beats=%0d sat_beats=%0d", out_data, out_beats, out_beats_s);
            end
        end
    end

    // Present one beat and hold it until accepted. Returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last,
                             input logic [2:0] o, input logic f, output int waits);
        logic done;
        in_a = a; in_b = b; in_last = last; op = o; fold = f; in_valid = 1'b1;
        waits = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else begin
                waits++;
                if (waits >= 50) begin
                    total_cnt++;
                    $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            total_cnt++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
    endtask

    task automatic pair(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        int w;
        logic [7:0] r;
        r = base_op(a, b, o[1:0]);
        if (o[2]) r = ~r;
        push_exp(r, 1);
        send_beat(a, b, 1'b0, o, 1'b0, w);
        $display("pair op=%03b a=%02h b=%02h exp=%02h", o, a, b, r);
    endtask

    // Fold one packet. o governs the packet; o_later is driven on beats after the first.
    task automatic fold_pkt(input logic [2:0] o, input logic [2:0] o_later, input logic [7:0] beats[$]);
        int w;
        logic [7:0] acc;
        drain();
        acc = beats[0];
        for (int i = 1; i < beats.size(); i++) acc = base_op(acc, beats[i], o[1:0]);
        if (o[2]) acc = ~acc;
        for (int i = 0; i < beats.size(); i++) begin
            if (i == beats.size() - 1) push_exp(acc, beats.size());
            send_beat(beats[i], 8'hAA, (i == beats.size() - 1), (i == 0) ? o : o_later, 1'b1, w);
            if (i != beats.size() - 1) begin
                total_cnt++;
                if (out_valid !== 1'b0)
                    $display("FAIL fold_no_early_valid: got out_valid=%0b after beat %0d, expected 0", out_valid, i);
                else pass_cnt++;
            end
        end
        $display("fold op=%03b beats=%0d exp=%02h", o, beats.size(), acc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); else pass_cnt++;
        total_cnt++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data: got %02h, expected 00", out_data); else pass_cnt++;
        total_cnt++;
        if (out_beats !== 8'd0) $display("FAIL reset_out_beats: got %0d, expected 0", out_beats); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); else pass_cnt++;
        $display("reset checked");
    endtask

    task automatic test_pair();
        pair(8'hF0, 8'h3C, 3'b000);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h30 || out_beats !== 8'd1)
            $display("FAIL pair_latency: got v=%0b data=%02h beats=%0d, expected v=1 data=30 beats=1",
                     out_valid, out_data, out_beats);
        else pass_cnt++;
        pair(8'hF0, 8'h3C, 3'b110);
        pair(8'hF0, 8'h3C, 3'b001);
        pair(8'hF0, 8'h3C, 3'b101);
        pair(8'hF0, 8'h3C, 3'b010);
        pair(8'hF0, 8'h3C, 3'b100);
        pair(8'hF0, 8'h3C, 3'b011);
        pair(8'hF0, 8'h3C, 3'b111);
        drain();
    endtask

    task automatic test_fold();
        logic [7:0] q[$];
        q = {8'h01, 8'h02, 8'h04};
        fold_pkt(3'b010, 3'b010, q);
        q = {8'hFF, 8'h0F};
        fold_pkt(3'b100, 3'b100, q);
        q = {8'h5A};
        fold_pkt(3'b101, 3'b101, q);
        drain();
    endtask

    task automatic test_backpressure();
        int w;
        drain();
        out_ready = 1'b0;
        push_exp(8'h30, 1);
        send_beat(8'hF0, 8'h3C, 1'b0, 3'b000, 1'b0, w);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h30 || out_beats !== 8'd1)
                $display("FAIL stall_hold: cycle %0d got rdy=%0b v=%0b data=%02h beats=%0d, expected rdy=0 v=1 data=30 beats=1",
                         k, in_ready, out_valid, out_data, out_beats);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_exp(8'hCC, 1);
        send_beat(8'hF0, 8'h3C, 1'b0, 3'b010, 1'b0, w);
        total_cnt++;
        if (w !== 0) $display("FAIL same_cycle_accept: got %0d wait cycles, expected 0", w); else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'hCC)
            $display("FAIL reload_after_stall: got v=%0b data=%02h, expected v=1 data=CC", out_valid, out_data);
        else pass_cnt++;
        $display("backpressure checked");
        drain();
    endtask

    task automatic test_mid_packet();
        logic [7:0] q[$];
        q = {8'h11, 8'h22, 8'h44};
        fold_pkt(3'b010, 3'b000, q);
        drain();
    endtask

    task automatic test_reset_mid_packet();
        int w;
        logic [7:0] q[$];
        drain();
        send_beat(8'h33, 8'h00, 1'b0, 3'b010, 1'b1, w);
        send_beat(8'h55, 8'h00, 1'b0, 3'b010, 1'b1, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_beats !== 8'd0 || in_ready !== 1'b1)
            $display("FAIL mid_reset: got v=%0b data=%02h beats=%0d rdy=%0b, expected v=0 data=00 beats=0 rdy=1",
                     out_valid, out_data, out_beats, in_ready);
        else pass_cnt++;
        $display("reset mid-packet checked");
        q = {8'h0F, 8'hF0};
        fold_pkt(3'b010, 3'b010, q);
        drain();
    endtask

    task automatic test_saturation();
        logic [7:0] q[$];
        q = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        fold_pkt(3'b001, 3'b001, q);
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        logic [7:0] a, b, r;
        logic [2:0] o;
        drain();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            o = 3'($urandom_range(0, 7));
            r = base_op(a, b, o[1:0]);
            if (o[2]) r = ~r;
            push_exp(r, 1);
            send_beat(a, b, 1'b0, o, 1'b0, w);
            total_cnt++;
            if (w !== 0) $display("FAIL back_to_back_stall: beat %0d got %0d waits, expected 0", i, w);
            else pass_cnt++;
            $display("b2b op=%03b a=%02h b=%02h exp=%02h", o, a, b, r);
        end
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_pair();
        test_fold();
        test_backpressure();
        test_mid_packet();
        test_reset_mid_packet();
        test_saturation();
        test_back_to_back();
        drain();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL leftover_results: got %0d unconsumed, expected 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
